// File: rtl/trail_scheduler.sv
// rtl/trail_scheduler.sv - per-frame trail particle table: walk/age one slot per clock, then spawn
// Optional feature macro: TRAIL_JITTER_EN (LFSR-based spawn y jitter).
module trail_scheduler #(
  parameter int N_TRAIL     = 41,
  parameter int LIFE_MAX    = 10,
  parameter int SPAWN_DIV   = 2,
  parameter int DRIFT       = 2,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic [1:0]               gamemode,
  input  logic [8:0]               player_y,
  output logic [N_TRAIL-1:0][9:0]  trail_x,
  output logic [N_TRAIL-1:0][8:0]  trail_y,
  output logic [N_TRAIL-1:0][3:0]  trail_life,
  output logic                     busy
);

  localparam int IW = (N_TRAIL > 1) ? $clog2(N_TRAIL) : 1;
  localparam logic [1:0] MODE_START = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_PAUSE = 2'b10;

  typedef enum logic [1:0] {IDLE, WALK, SPAWN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rd_idx, rd_idx_nxt, wr_ptr;
  logic [3:0]    frame_cnt;
  logic          walk_en, spawn_en, fc_inc, clear;
  logic [9:0]    jitter, spawn_y_raw;
  logic [8:0]    spawn_y;

`ifdef TRAIL_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // lfsr[2:0] - 4 in modulo-1024 arithmetic; the final sum is never negative
  assign jitter = {7'd0, lfsr[2:0]} - 10'd4;
`else
  assign jitter = '0;
`endif

  assign spawn_y_raw = {1'b0, player_y} + 10'(PLAYER_SIZE / 2) + jitter;
  assign spawn_y     = (spawn_y_raw < 10'd21)  ? 9'd21  :
                       (spawn_y_raw > 10'd459) ? 9'd459 : spawn_y_raw[8:0];

  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    walk_en    = 1'b0;
    spawn_en   = 1'b0;
    fc_inc     = 1'b0;
    clear      = 1'b0;
    if (gamemode == MODE_START) begin
      clear      = 1'b1;
      state_nxt  = IDLE;
      rd_idx_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          // bit 0 set means running or game over, the two modes that age the trail
          if (frame_tick && gamemode[0]) begin
            state_nxt  = WALK;
            rd_idx_nxt = '0;
          end
        end
        WALK: begin
          if (gamemode != MODE_PAUSE) begin
            walk_en = 1'b1;
            if (rd_idx == IW'(N_TRAIL - 1)) state_nxt = SPAWN;
            else                            rd_idx_nxt = rd_idx + 1'b1;
          end
        end
        SPAWN: begin
          if (gamemode != MODE_PAUSE) begin
            state_nxt = IDLE;
            if (gamemode == MODE_RUN) begin
              if (frame_cnt == 4'(SPAWN_DIV - 1)) spawn_en = 1'b1;
              else                                fc_inc   = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_idx    <= '0;
      wr_ptr    <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < N_TRAIL; i++) begin
        trail_x[i]    <= '0;
        trail_y[i]    <= '0;
        trail_life[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      rd_idx <= rd_idx_nxt;
      busy   <= (state_nxt != IDLE);
      if (clear) begin
        wr_ptr    <= '0;
        frame_cnt <= '0;
        for (int i = 0; i < N_TRAIL; i++) trail_life[i] <= '0;
      end else begin
        if (walk_en && trail_life[rd_idx] != 4'd0) begin
          if (trail_x[rd_idx] < 10'(DRIFT)) begin
            trail_life[rd_idx] <= 4'd0;
          end else begin
            trail_x[rd_idx]    <= trail_x[rd_idx] - 10'(DRIFT);
            trail_life[rd_idx] <= trail_life[rd_idx] - 4'd1;
          end
        end
        if (spawn_en) begin
          trail_x[wr_ptr]    <= 10'(PLAYER_X);
          trail_y[wr_ptr]    <= spawn_y;
          trail_life[wr_ptr] <= 4'(LIFE_MAX);
          wr_ptr             <= (wr_ptr == IW'(N_TRAIL - 1)) ? '0 : wr_ptr + 1'b1;
          frame_cnt          <= '0;
        end else if (fc_inc) begin
          frame_cnt <= frame_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trail_scheduler.sv
// tb/tb_trail_scheduler.sv - randomized, model-checked bench for trail_scheduler
module tb_trail_scheduler;

  localparam int N     = 41;
  localparam int LMAX  = 10;
  localparam int SDIV  = 2;
  localparam int DRIFT = 2;
  localparam int PX    = 160;
  localparam int HALF  = 20;
  localparam int PX2   = 30;
  localparam int DRIFT2 = 8;
`ifdef TRAIL_JITTER_EN
  localparam int JLO = -4;
  localparam int JHI = 3;
`else
  localparam int JLO = 0;
  localparam int JHI = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic [1:0] gamemode = 2'b00;
  logic [8:0] player_y = 9'd0;
  logic [N-1:0][9:0] trail_x, d2_x;
  logic [N-1:0][8:0] trail_y, d2_y;
  logic [N-1:0][3:0] trail_life, d2_life;
  logic busy, d2_busy;

  trail_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
    .player_y(player_y), .trail_x(trail_x), .trail_y(trail_y),
    .trail_life(trail_life), .busy(busy)
  );

  // second instance whose spawn x is close enough to the left edge to hit the edge kill
  trail_scheduler #(.PLAYER_X(PX2), .DRIFT(DRIFT2)) dut2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
    .player_y(player_y), .trail_x(d2_x), .trail_y(d2_y),
    .trail_life(d2_life), .busy(d2_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_x[N], m_ylo[N], m_yhi[N], m_life[N];
  int m_wp, m_fc;

  function automatic int clampy(int v);
    return (v < 21) ? 21 : ((v > 459) ? 459 : v);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_life[i] = 0;
    m_wp = 0;
    m_fc = 0;
  endfunction

  // one whole accepted frame: age every live particle, then maybe spawn
  function automatic void model_frame(int mode, int py);
    for (int i = 0; i < N; i++) begin
      if (m_life[i] != 0) begin
        if (m_x[i] < DRIFT) m_life[i] = 0;
        else begin
          m_x[i] -= DRIFT;
          m_life[i] -= 1;
        end
      end
    end
    if (mode == 1) begin
      if (m_fc == SDIV - 1) begin
        m_x[m_wp]    = PX;
        m_ylo[m_wp]  = clampy(py + HALF + JLO);
        m_yhi[m_wp]  = clampy(py + HALF + JHI);
        m_life[m_wp] = LMAX;
        m_wp = (m_wp + 1) % N;
        m_fc = 0;
      end else m_fc += 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [8:0] py, input string tag);
    int n, exp_n;
    gamemode = mode;
    player_y = py;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    if (mode == 2'b01 || mode == 2'b11) begin
      model_frame(int'(mode), int'(py));
      exp_n = N + 1;
    end else begin
      if (mode == 2'b00) model_clear();
      exp_n = 0;
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, n, exp_n);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (trail_life[i] !== 4'(m_life[i])) begin
        errors++;
        $display("FAIL %s life[%0d]: got %0d want %0d", tag, i, trail_life[i], m_life[i]);
      end
      if (m_life[i] != 0) begin
        checks++;
        if (trail_x[i] !== 10'(m_x[i])) begin
          errors++;
          $display("FAIL %s x[%0d]: got %0d want %0d", tag, i, trail_x[i], m_x[i]);
        end
        checks++;
        if (int'(trail_y[i]) < m_ylo[i] || int'(trail_y[i]) > m_yhi[i]) begin
          errors++;
          $display("FAIL %s y[%0d]: got %0d want %0d..%0d", tag, i, trail_y[i], m_ylo[i], m_yhi[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    gamemode = 2'b01;
    step();
    step();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_ylo[i] = 0; m_yhi[i] = 0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    bad = 0;
    for (int i = 0; i < N; i++) if (trail_life[i] !== 4'd0 || trail_x[i] !== 10'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_table: got %0d nonzero slots want 0", bad);
    end
    repeat (42) step();
    bad = 0;
    for (int i = 0; i < N; i++) if (trail_life[i] !== 4'd0) bad++;
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got %0d live slots busy=%b want 0 and 0", bad, busy);
    end
  endtask

  task automatic test_first_spawn();
    run_frame(2'b01, 9'd100, "spawn_tick1");
    run_frame(2'b01, 9'd100, "spawn_tick2");
    checks++;
    if (trail_x[0] !== 10'd160 || trail_life[0] !== 4'd10) begin
      errors++;
      $display("FAIL first_spawn: got x=%0d life=%0d want x=160 life=10", trail_x[0], trail_life[0]);
    end
`ifndef TRAIL_JITTER_EN
    checks++;
    if (trail_y[0] !== 9'd120) begin
      errors++;
      $display("FAIL first_spawn_y: got %0d want 120", trail_y[0]);
    end
`endif
    run_frame(2'b01, 9'd100, "spawn_tick3");
    checks++;
    if (trail_x[0] !== 10'd158 || trail_life[0] !== 4'd9) begin
      errors++;
      $display("FAIL aged_once: got x=%0d life=%0d want x=158 life=9", trail_x[0], trail_life[0]);
    end
  endtask

  task automatic test_clamp();
    run_frame(2'b01, 9'd0, "clamp_lo");
    run_frame(2'b01, 9'd500, "clamp_hi_a");
    run_frame(2'b01, 9'd500, "clamp_hi_b");
`ifndef TRAIL_JITTER_EN
    checks++;
    if (trail_y[1] !== 9'd21 || trail_y[2] !== 9'd459) begin
      errors++;
      $display("FAIL clamp_y: got %0d,%0d want 21,459", trail_y[1], trail_y[2]);
    end
`endif
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 84; k++) run_frame(2'b01, 9'($urandom_range(0, 511)), "wrap");
  endtask

  task automatic test_left_edge();
    int ex, el;
    run_frame(2'b00, 9'd100, "edge_clear");
    run_frame(2'b01, 9'd100, "edge_pre1");
    run_frame(2'b01, 9'd100, "edge_pre2");
    ex = PX2;
    el = LMAX;
    checks++;
    if (d2_x[0] !== 10'(ex) || d2_life[0] !== 4'(el) ||
        int'(d2_y[0]) < 120 + JLO || int'(d2_y[0]) > 120 + JHI) begin
      errors++;
      $display("FAIL edge_spawn: got x=%0d y=%0d life=%0d want x=%0d y=120 life=%0d",
               d2_x[0], d2_y[0], d2_life[0], ex, el);
    end
    for (int k = 1; k <= 12; k++) begin
      run_frame(2'b11, 9'd100, "edge_over");
      if (el != 0) begin
        if (ex < DRIFT2) el = 0;
        else begin
          ex -= DRIFT2;
          el -= 1;
        end
      end
      checks++;
      if (d2_life[0] !== 4'(el) || d2_x[0] !== 10'(ex) || d2_busy !== 1'b0) begin
        errors++;
        $display("FAIL edge_kill tick %0d: got x=%0d life=%0d busy=%b want x=%0d life=%0d busy=0",
                 k, d2_x[0], d2_life[0], d2_busy, ex, el);
      end
    end
  endtask

  task automatic test_pause();
    logic [N-1:0][3:0] snap_life;
    logic [N-1:0][9:0] snap_x;
    int n;
    for (int k = 0; k < 6; k++) run_frame(2'b01, 9'($urandom_range(0, 480)), "pause_fill");
    gamemode = 2'b01;
    player_y = 9'd200;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (9) step();
    gamemode = 2'b10;
    snap_life = trail_life;
    snap_x = trail_x;
    for (int c = 0; c < 50; c++) begin
      step();
      checks++;
      if (busy !== 1'b1 || trail_life !== snap_life || trail_x !== snap_x) begin
        errors++;
        $display("FAIL pause_hold cycle %0d: busy=%b table_changed=%b want busy=1 unchanged",
                 c, busy, (trail_life !== snap_life) || (trail_x !== snap_x));
      end
    end
    gamemode = 2'b01;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL pause_resume: got %0d busy cycles after resume want 33", n);
    end
    model_frame(1, 200);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (trail_life[i] !== 4'(m_life[i]) || (m_life[i] != 0 && trail_x[i] !== 10'(m_x[i]))) begin
        errors++;
        $display("FAIL pause_result[%0d]: got x=%0d life=%0d want x=%0d life=%0d",
                 i, trail_x[i], trail_life[i], m_x[i], m_life[i]);
      end
    end
  endtask

  task automatic test_dropped_tick();
    int n, late;
    gamemode = 2'b01;
    player_y = 9'd150;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (4) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n !== 37) begin
      errors++;
      $display("FAIL dropped_tick: got %0d busy cycles after t+6 want 37", n);
    end
    late = 0;
    for (int c = 0; c < 50; c++) begin
      if (busy) late++;
      step();
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL dropped_tick_queued: got %0d busy cycles want 0", late);
    end
    model_frame(1, 150);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (trail_life[i] !== 4'(m_life[i])) begin
        errors++;
        $display("FAIL dropped_result life[%0d]: got %0d want %0d", i, trail_life[i], m_life[i]);
      end
    end
  endtask

  task automatic test_clear();
    int bad;
    run_frame(2'b01, 9'd300, "clear_fill");
    run_frame(2'b01, 9'd300, "clear_fill");
    gamemode = 2'b01;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (9) step();
    gamemode = 2'b00;
    step();
    model_clear();
    bad = 0;
    for (int i = 0; i < N; i++) if (trail_life[i] !== 4'd0) bad++;
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_midwalk: got %0d live slots busy=%b want 0 and 0", bad, busy);
    end
    gamemode = 2'b01;
    step();
  endtask

  task automatic test_random();
    int r, gap;
    logic [1:0] mode;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 2'b00 : (r < 3) ? 2'b10 : (r < 6) ? 2'b11 : 2'b01;
      gap = $urandom_range(0, 20);
      repeat (gap) step();
      run_frame(mode, 9'($urandom_range(0, 511)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_clamp();
    test_wrap();
    test_left_edge();
    test_pause();
    test_dropped_tick();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trail_scheduler.md
# trail_scheduler

Owns the 41-entry player trail particle table consumed by the VGA pixel generator (`trail_x`, `trail_y`, `trail_life`). Once per video frame it walks the table one slot per clock to age and scroll every particle, then writes a new particle behind the player into a circular slot. The walk runs during vertical blanking, so the table never changes while pixels are being drawn. The block follows `gamemode`: it clears the table on the start screen, freezes it while paused and lets the trail fade out after game over.

## Interface
Parameters:
- `N_TRAIL`, 41: number of table slots.
- `LIFE_MAX`, 10: life value of a new particle.
- `SPAWN_DIV`, 2: a particle is spawned every `SPAWN_DIV` accepted frames. Legal range is 1..15.
- `DRIFT`, 2: leftward scroll per accepted frame, in pixels.
- `PLAYER_X`, 160: player left edge. This is also the spawn x.
- `PLAYER_SIZE`, 40: player sprite size.

Ports:
- `clk`, in, 1: pixel clock. This is the only clock.
- `rst`, in, 1: synchronous reset, active-high.
- `frame_tick`, in, 1: one-cycle pulse at the start of vertical blanking.
- `gamemode`, in, 2: 00 start screen, 01 running, 10 paused, 11 game over.
- `player_y`, in, 9: player top edge.
- `trail_x`, out, [N_TRAIL-1:0][9:0]: particle centre x.
- `trail_y`, out, [N_TRAIL-1:0][8:0]: particle centre y.
- `trail_life`, out, [N_TRAIL-1:0][3:0]: particle life. 0 means the slot is invisible.
- `busy`, out, 1: high while a walk or spawn is in progress.

## Operation
- **Reset values:** all `trail_x`, `trail_y` and `trail_life` entries are 0. `busy` is 0. The state is IDLE. `wr_ptr`, `rd_idx` and `frame_cnt` are 0. The LFSR is 8'hA5.
- **IDLE:**
  - A `frame_tick` with `gamemode` equal to 01 or 11 is accepted and the state moves to WALK with `rd_idx` = 0.
  - A `frame_tick` in mode 10 is ignored.
  - A `frame_tick` in mode 00 is ignored.
- **WALK:** slot `rd_idx` is updated as follows.
  - If its life is nonzero, life is decremented by 1.
  - If `x` < `DRIFT`, life is forced to 0 and `x` is left unchanged. Otherwise `x` = `x` - `DRIFT`.
  - `y` is unchanged.
  - Slots with life 0 are not touched.
  - `rd_idx` then increments. After slot `N_TRAIL`-1 the state moves to SPAWN.
- **SPAWN:**
  - A particle is written only if `gamemode` is 01 and `frame_cnt` equals `SPAWN_DIV`-1. In that case slot `wr_ptr` gets `x` = `PLAYER_X`, `y` = `player_y` + `PLAYER_SIZE`/2 + jitter, and life = `LIFE_MAX`.
  - `wr_ptr` wraps from `N_TRAIL`-1 to 0, so the oldest slot is overwritten.
  - `frame_cnt` is 0 after a spawn. Otherwise, in mode 01, it increments.
  - In mode 11 there is no spawn and `frame_cnt` holds.
  - The state then returns to IDLE.
- **Mode 00 (any state):**
  - Every life is cleared to 0 in one cycle.
  - `wr_ptr` and `frame_cnt` go to 0, the state goes to IDLE and `busy` goes to 0.
  - `x` and `y` values are don't-care.
- **Mode 10 during WALK or SPAWN:** the walk stalls. `rd_idx` holds and no slot changes until the mode leaves 10, then the walk resumes where it stopped.
- **`frame_tick` while `busy`:** the tick is dropped and no queueing takes place.
- **Width and arithmetic rules:**
  - Spawn y is computed at 10 bits, then clamped to the range 21..459 and truncated to 9 bits.
  - Life arithmetic saturates at 0.
- **LFSR:** polynomial x^8+x^6+x^5+x^4+1. It advances every clock, including while idle, and does not advance during reset.

## Timing
- `frame_tick` is accepted in cycle t.
- `busy` is high from t+1 through t+`N_TRAIL`+1.
- Slot i is updated at the clock edge that ends cycle t+1+i.
- The spawn write lands at the edge that ends cycle t+`N_TRAIL`+1. With the default `N_TRAIL` that is t+42.
- The state is IDLE again at t+`N_TRAIL`+2.
- Total update latency is therefore 42 cycles. This fits easily inside blanking, which is about 36k cycles.
- All outputs are registered and change only in the cycles listed above, or in the single clear cycle of mode 00.

## Configuration
- `TRAIL_JITTER_EN` defined: jitter = `lfsr[2:0]` - 4, a signed value in the range -4..+3. This gives a scattered trail.
- `TRAIL_JITTER_EN` undefined: jitter = 0 and the LFSR is not instantiated. Spawn y is exactly `player_y` + 20.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> all lives are 0, `busy` is 0, and 42 cycles later nothing has changed without a tick.
- **First spawn:**
  - Setup: mode 01, `player_y` = 100, jitter disabled, `SPAWN_DIV` = 2, two ticks 100 cycles apart.
  - The first tick produces no spawn.
  - After the second tick, slot 0 holds x=160, y=120, life=10 at t+42.
  - After the third tick, slot 0 holds x=158, life=9.
- **Wrap and overwrite:**
  - Setup: `SPAWN_DIV` = 1 and 42 ticks in mode 01.
  - Slot 0 is rewritten on the 42nd tick with life 10 and x 160.
  - Slot 1 holds life 0, because its life expired after 10 frames.
- **Left-edge kill:** preload a particle by spawning, then apply 80 ticks in mode 11 with `DRIFT` = 2 -> life reaches 0 by the 10th tick and no new spawns occur.
- **Pause stall:**
  - Setup: a tick is accepted, then mode is set to 10 at t+10 for 50 cycles and then back to 01.
  - During the pause, slots 9 onward are unchanged and `busy` stays high.
  - After returning to 01, the walk completes at t+92.
- **Clear and dropped tick:**
  - A tick at t+5 during a walk is dropped, so `busy` falls at t+43.
  - Switching to mode 00 mid-walk clears all lives on the next edge and `busy` drops to 0.
